gate_sweep_controller: RTL and testbench

Self-checking sequencer for a 2-input/1-output combinational gate such as simple_example_module. On a start request it steps {a,b} through all four input combinations (00, 01, 10, 11), waits a settle time, samples the gate output and compares it against a parameterised truth table. It then reports a pass/fail summary with error count and first failing vector. It sits between a lab top level (buttons/LEDs or a bench) and the gate under test.

---
 rtl/gate_sweep_controller.sv | 118 +++++++++++
 tb/tb_gate_sweep_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_controller.sv
// Sweeps a 2-input gate through {a,b} = 00,01,10,11, samples its output after a
// settle delay and reports error count, first failing vector and pass/fail.
module gate_sweep_controller #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  EXPECTED      = 4'b0001
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  output logic       o_a,
  output logic       o_b,
  input  logic       i_c,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [2:0] o_err_count,
  output logic [1:0] o_first_fail,
  output logic       o_first_fail_valid,
  output logic [1:0] o_state_dbg
);

  // Encoding is visible on o_state_dbg: IDLE=0, SETTLE=1, SAMPLE=2, DONE=3.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [1:0] ff_q, ff_d;
  logic       ffv_q, ffv_d;
  logic       mismatch;
  logic       busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 3'd0;
      ff_q    <= 2'd0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  // i_start is a level request: it is only looked at in IDLE and DONE, and is
  // simply ignored while a sweep is running (no queueing, no restart).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ff_d     = ff_q;
    ffv_d    = ffv_q;
    mismatch = (i_c !== EXPECTED[idx_q]);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          idx_d   = 2'd0;
          cnt_d   = SETTLE_LOAD;
          err_d   = 3'd0;
          ff_d    = 2'd0;
          ffv_d   = 1'b0;
          state_d = (SETTLE_LOAD == 4'd0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 3'd1;
          if (!ffv_q) begin
            ff_d  = idx_q;
            ffv_d = 1'b1;
          end
        end
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = (SETTLE_LOAD == 4'd0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode registered state only; i_c never reaches an output directly.
  always_comb begin
    busy               = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    o_busy             = busy;
    o_a                = busy & idx_q[1];
    o_b                = busy & idx_q[0];
    o_done             = (state_q == ST_DONE);
    o_pass             = (state_q == ST_DONE) && (err_q == 3'd0);
    o_err_count        = err_q;
    o_first_fail       = ff_q;
    o_first_fail_valid = ffv_q;
    o_state_dbg        = state_q;
  end

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Bench for gate_sweep_controller: two instances (settle 1 and settle 0) driven
// by truth-table gate models; table vectors, corner sequences and random sweeps.
module tb_gate_sweep_controller;

  logic clk = 1'b0;
  logic rst;
  logic start1, start0;
  logic a1, b1, c1, busy1, done1, pass1, ffv1;
  logic a0, b0, c0, busy0, done0, pass0, ffv0;
  logic [2:0] err1, err0;
  logic [1:0] ff1, ff0, dbg1, dbg0;
  logic [3:0] tt1, tt0;

  localparam logic [3:0] NOR_TT = 4'b0001;

  always #5 clk = ~clk;

  // Gate models: output indexed by {a,b}.
  assign c1 = tt1[{a1, b1}];
  assign c0 = tt0[{a0, b0}];

  gate_sweep_controller #(.SETTLE_CYCLES(1), .EXPECTED(NOR_TT)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start1), .o_a(a1), .o_b(b1), .i_c(c1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
    .o_first_fail(ff1), .o_first_fail_valid(ffv1), .o_state_dbg(dbg1)
  );

  gate_sweep_controller #(.SETTLE_CYCLES(0), .EXPECTED(NOR_TT)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start0), .o_a(a0), .o_b(b0), .i_c(c0),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_count(err0),
    .o_first_fail(ff0), .o_first_fail_valid(ffv0), .o_state_dbg(dbg0)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] tt;
    logic [2:0] err;
    logic [1:0] ff;
    logic       ffv;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: mismatch count is the popcount of the truth-table difference,
  // first failure the lowest differing index.
  function automatic void model(input logic [3:0] tt, output logic [2:0] err,
                                output logic [1:0] ff, output logic ffv);
    err = 3'd0; ff = 2'd0; ffv = 1'b0;
    for (int v = 0; v < 4; v++) begin
      if (tt[v] != NOR_TT[v]) begin
        err = err + 3'd1;
        if (!ffv) begin
          ff  = 2'(v);
          ffv = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [3:0] obs(input bit sel);
    return sel ? {busy1, done1, a1, b1} : {busy0, done0, a0, b0};
  endfunction

  function automatic logic [6:0] res(input bit sel);
    return sel ? {err1, ff1, ffv1, pass1} : {err0, ff0, ffv0, pass0};
  endfunction

  function automatic logic [12:0] all_outs(input bit sel);
    return sel ? {busy1, done1, pass1, a1, b1, err1, ff1, ffv1, dbg1}
               : {busy0, done0, pass0, a0, b0, err0, ff0, ffv0, dbg0};
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v; else start0 = v;
  endtask

  // Starts a sweep from IDLE/DONE, checks the vector walk every cycle and the
  // edge at which o_done rises; optionally pulses start at busy cycle pulse_at.
  task automatic sweep(input bit sel, input logic [3:0] tt, input int pulse_at, input string tag);
    int hold;
    int total;
    hold  = sel ? 2 : 1;
    total = 4 * hold;
    if (sel) tt1 = tt; else tt0 = tt;
    set_start(sel, 1'b1);
    @(negedge clk);
    chk({tag, " cleared"}, {res(sel)[6:4], res(sel)[1]}, 4'b0000);
    for (int n = 0; n < total; n++) begin
      chk({tag, " walk"}, obs(sel), {2'b10, 2'(n / hold)});
      set_start(sel, n == pulse_at);
      @(negedge clk);
    end
    set_start(sel, 1'b0);
    chk({tag, " done"}, obs(sel), 4'b0100);
  endtask

  task automatic check_res(input bit sel, input logic [2:0] err, input logic [1:0] ff,
                           input logic ffv, input string tag);
    chk({tag, " result"}, res(sel), {err, ff, ffv, err == 3'd0});
  endtask

  logic [2:0] m_err;
  logic [1:0] m_ff;
  logic       m_ffv;

  initial begin
    vecs[0] = '{"nor",      4'b0001, 3'd0, 2'd0, 1'b0};
    vecs[1] = '{"stuck1",   4'b1111, 3'd3, 2'd1, 1'b1};
    vecs[2] = '{"not_a",    4'b0011, 3'd1, 2'd1, 1'b1};
    vecs[3] = '{"stuck0",   4'b0000, 3'd1, 2'd0, 1'b1};
    vecs[4] = '{"and",      4'b1000, 3'd2, 2'd0, 1'b1};
    vecs[5] = '{"nand",     4'b0111, 3'd2, 2'd1, 1'b1};
    vecs[6] = '{"xor",      4'b0110, 3'd3, 2'd0, 1'b1};
    vecs[7] = '{"or",       4'b1110, 3'd4, 2'd0, 1'b1};

    rst = 1'b1; start1 = 1'b0; start0 = 1'b0; tt1 = NOR_TT; tt0 = NOR_TT;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset dut1", all_outs(1'b1), 13'd0);
    chk("reset dut0", all_outs(1'b0), 13'd0);
    @(negedge clk);
    chk("idle dut1", all_outs(1'b1), 13'd0);

    // Back-to-back sweeps restart from DONE, so each one also proves clearing.
    for (int i = 0; i < 8; i++) begin
      sweep(1'b1, vecs[i].tt, -1, vecs[i].name);
      check_res(1'b1, vecs[i].err, vecs[i].ff, vecs[i].ffv, vecs[i].name);
    end

    sweep(1'b0, NOR_TT, -1, "s0 nor");
    check_res(1'b0, 3'd0, 2'd0, 1'b0, "s0 nor");
    @(negedge clk);
    chk("s0 done held", obs(1'b0), 4'b0100);

    // Start pulsed during the third busy cycle must not stretch or restart.
    sweep(1'b1, 4'b1111, 2, "busy pulse");
    check_res(1'b1, 3'd3, 2'd1, 1'b1, "busy pulse");
    repeat (2) @(negedge clk);
    chk("done held", res(1'b1), {3'd3, 2'd1, 1'b1, 1'b0});
    sweep(1'b1, NOR_TT, -1, "restart");
    check_res(1'b1, 3'd0, 2'd0, 1'b0, "restart");

    // Continuous start: one DONE cycle per 9-cycle sweep.
    begin
      int n_done;
      int n_consec;
      logic prev;
      n_done = 0; n_consec = 0; prev = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      for (int n = 1; n <= 27; n++) begin
        if (done1) n_done++;
        if (done1 && prev) n_consec++;
        prev = done1;
        if (n == 27) start1 = 1'b0;
        @(negedge clk);
      end
      chk("held start done count", n_done, 3);
      chk("held start done width", n_consec, 0);
      chk("held start final done", {done1, pass1}, 2'b11);
    end

    // Reset in the middle of vector 10 wipes partial results.
    tt1 = 4'b1111;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset vector", obs(1'b1), 4'b1010);
    chk("pre-reset err", err1, 3'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset", all_outs(1'b1), 13'd0);
    @(negedge clk);
    chk("post reset idle", all_outs(1'b1), 13'd0);
    sweep(1'b1, NOR_TT, -1, "after reset");
    check_res(1'b1, 3'd0, 2'd0, 1'b0, "after reset");
    @(negedge clk);
    sweep(1'b0, 4'b1111, -1, "s0 stuck1");
    check_res(1'b0, 3'd3, 2'd1, 1'b1, "s0 stuck1");

    // Random gates, idle gaps and stray start pulses on both instances.
    for (int i = 0; i < 24; i++) begin
      bit sel;
      logic [3:0] tt;
      int gap;
      int pulse;
      sel   = 1'($urandom_range(0, 1));
      tt    = 4'($urandom);
      gap   = $urandom_range(0, 3);
      pulse = $urandom_range(0, 1) ? $urandom_range(0, sel ? 7 : 3) : -1;
      repeat (gap) @(negedge clk);
      model(tt, m_err, m_ff, m_ffv);
      sweep(sel, tt, pulse, "random");
      check_res(sel, m_err, m_ff, m_ffv, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

endmodule
